// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//   Measures the period of a slow, possibly asynchronous square wave in
//   system-clock cycles. Each rising edge of sig_in closes the running period
//   and opens the next one. A stalled input produces a timeout pulse once the
//   counter saturates.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   measurement enable (synchronous to clk)
//   sig_in       in   signal under measurement (may be asynchronous)
//   period_out   out  last measured period in clk cycles, held between updates
//   period_valid out  one-cycle pulse when period_out has just been updated
//   timeout      out  one-cycle pulse when no rise arrives within 2^CNT_W-1
//   busy         out  high while a measurement is in progress
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 resets low, so an input held high through reset yields one rise,
  // which can only arm the measurement.
  assign rise = s2 & ~s3;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= CNT_ZERO;
      period_out   <= CNT_ZERO;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      period_out   <= period_nxt;
      period_valid <= valid_nxt;
      timeout      <= timeout_nxt;
    end
  end

  // Next-state logic; in MEASURE, disable beats rise, and rise beats the
  // saturation check, so a rise landing on the maximum count is a valid period.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    period_nxt  = period_out;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise && en) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = MEASURE;
        end else begin
          cnt_nxt   = CNT_ZERO;
          state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (!en) begin
          cnt_nxt   = CNT_ZERO;
          state_nxt = IDLE;
        end else if (rise) begin
          period_nxt = cnt;
          valid_nxt  = 1'b1;
          cnt_nxt    = CNT_ONE;
          state_nxt  = MEASURE;
        end else if (cnt == CNT_MAX) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = CNT_ZERO;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
          state_nxt = MEASURE;
        end
      end
      default: begin
        cnt_nxt   = CNT_ZERO;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == MEASURE);

endmodule
